// File: rtl/prbs8_checker.sv
// Receive-side checker for the 8-bit LFSR word stream: self-synchronises,
// flywheels the prediction once locked and counts mismatches.
module prbs8_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MISS_MAX = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       expected
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           pred_q, pred_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 locked_q, locked_d;
    logic                 mism_c;

    function automatic logic [7:0] step8(input logic [7:0] c);
        return {c[4] ^ c[3] ^ c[2] ^ c[0], c[7:1]};
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            pred_q      <= 8'h00;
            match_q     <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    // Next state, prediction and sync counters; only valid words advance anything
    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_data != 8'h00) begin
                        pred_d  = step8(in_data);
                        match_d = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (in_data == pred_q) begin
                        pred_d  = step8(pred_q);
                        match_d = match_q + MATCH_W'(1);
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (in_data != 8'h00) begin
                        pred_d  = step8(in_data);
                        match_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    pred_d = step8(pred_q);
                    if (in_data == pred_q) begin
                        miss_d = '0;
                    end else if (miss_q == MISS_W'(MISS_MAX - 1)) begin
                        state_d = HUNT;
                        miss_d  = '0;
                        match_d = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output next values; a clear beats a coincident count
    always_comb begin
        mism_c      = in_valid && (state_q == LOCKED) && (in_data != pred_q);
        err_pulse_d = mism_c;
        locked_d    = (state_d == LOCKED);
        err_cnt_d   = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (mism_c && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign expected  = pred_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: vector table, hand sequences and a randomized run
// against a behavioural model, on a default instance and a narrow-counter instance.
module tb_prbs8_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clr_err;
    logic        locked_a, err_pulse_a, locked_b, err_pulse_b;
    logic [15:0] err_cnt_a;
    logic [1:0]  err_cnt_b;
    logic [7:0]  expected_a, expected_b;

    int nchk = 0;
    int nerr = 0;

    prbs8_checker #(.LOCK_CNT(4), .MISS_MAX(3), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clr_err(clr_err), .locked(locked_a), .err_pulse(err_pulse_a),
        .err_cnt(err_cnt_a), .expected(expected_a)
    );

    prbs8_checker #(.LOCK_CNT(4), .MISS_MAX(8), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clr_err(clr_err), .locked(locked_b), .err_pulse(err_pulse_b),
        .err_cnt(err_cnt_b), .expected(expected_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: st 0=hunt 1=sync 2=locked; counts as plain integers
    typedef struct {
        int         st;
        logic [7:0] pred;
        int         mat;
        int         mis;
        int         ec;
        bit         pl;
    } ms_t;

    ms_t ma, mb;

    function automatic logic [7:0] nxt(input logic [7:0] c);
        int fb;
        fb = $countones(c & 8'h1D) % 2;
        return 8'((int'(c) / 2) + fb * 128);
    endfunction

    function automatic ms_t mstep(input ms_t s, input bit v, input logic [7:0] d,
                                  input bit clr, input int lk, input int mm, input int emax);
        ms_t n;
        n = s;
        n.pl = 1'b0;
        if (v) begin
            if (s.st == 0) begin
                if (d != 8'h00) begin
                    n.pred = nxt(d); n.mat = 0; n.st = 1;
                end
            end else if (s.st == 1) begin
                if (d == s.pred) begin
                    n.pred = nxt(s.pred);
                    n.mat  = s.mat + 1;
                    if (n.mat == lk) begin n.st = 2; n.mis = 0; end
                end else if (d != 8'h00) begin
                    n.pred = nxt(d); n.mat = 0;
                end else begin
                    n.st = 0;
                end
            end else begin
                n.pred = nxt(s.pred);
                if (d == s.pred) begin
                    n.mis = 0;
                end else begin
                    n.pl = 1'b1;
                    if (s.ec < emax) n.ec = s.ec + 1;
                    n.mis = s.mis + 1;
                    if (n.mis == mm) begin n.st = 0; n.mis = 0; n.mat = 0; end
                end
            end
        end
        if (clr) n.ec = 0;
        return n;
    endfunction

    function automatic ms_t mreset();
        ms_t r;
        r.st = 0; r.pred = 8'h00; r.mat = 0; r.mis = 0; r.ec = 0; r.pl = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        ma = mstep(ma, in_valid, in_data, clr_err, 4, 3, 65535);
        mb = mstep(mb, in_valid, in_data, clr_err, 4, 8, 3);
        #1;
    endtask

    task automatic drv(input bit v, input logic [7:0] d, input bit c);
        in_valid = v;
        in_data  = d;
        clr_err  = c;
        cyc();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr_err  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ma = mreset();
        mb = mreset();
    endtask

    task automatic cmp_models(input string tag);
        chk({tag, " A.locked"},   32'(locked_a),    32'(ma.st == 2));
        chk({tag, " A.pulse"},    32'(err_pulse_a), 32'(ma.pl));
        chk({tag, " A.err_cnt"},  32'(err_cnt_a),   32'(ma.ec));
        chk({tag, " A.expected"}, 32'(expected_a),  32'(ma.pred));
        chk({tag, " B.locked"},   32'(locked_b),    32'(mb.st == 2));
        chk({tag, " B.pulse"},    32'(err_pulse_b), 32'(mb.pl));
        chk({tag, " B.err_cnt"},  32'(err_cnt_b),   32'(mb.ec));
        chk({tag, " B.expected"}, 32'(expected_b),  32'(mb.pred));
    endtask

    task automatic send_seq(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input logic [7:0] w3, input logic [7:0] w4);
        drv(1'b1, w0, 1'b0); drv(1'b1, w1, 1'b0); drv(1'b1, w2, 1'b0);
        drv(1'b1, w3, 1'b0); drv(1'b1, w4, 1'b0);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         clr;
        bit         lk;
        bit         pl;
        int         ec;
        logic [7:0] pr;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    initial begin
        logic [7:0] d;
        int r;

        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h80};
        tbl[1]  = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 0, 8'h40};
        tbl[2]  = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 0, 8'h20};
        tbl[3]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 0, 8'h10};
        tbl[4]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 0, 8'h88};
        tbl[5]  = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 0, 8'hC4};
        tbl[6]  = '{1'b1, 8'hC5, 1'b0, 1'b1, 1'b1, 1, 8'hE2};
        tbl[7]  = '{1'b1, 8'hE2, 1'b0, 1'b1, 1'b0, 1, 8'h71};
        tbl[8]  = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1, 8'h71};
        tbl[9]  = '{1'b1, 8'h71, 1'b0, 1'b1, 1'b0, 1, 8'h38};
        tbl[10] = '{1'b1, 8'h38, 1'b1, 1'b1, 1'b0, 0, 8'h1C};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1, 8'h8E};
        tbl[12] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 0, 8'h47};
        tbl[13] = '{1'b1, 8'h47, 1'b0, 1'b1, 1'b0, 0, 8'h23};
        tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1, 8'h91};
        tbl[15] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2, 8'h48};
        tbl[16] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3, 8'hA4};
        tbl[17] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 3, 8'h80};
        tbl[18] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 3, 8'h40};
        tbl[19] = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 3, 8'h20};
        tbl[20] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 3, 8'h10};
        tbl[21] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 3, 8'h88};

        do_reset();
        chk("reset locked",   32'(locked_a),    32'd0);
        chk("reset pulse",    32'(err_pulse_a), 32'd0);
        chk("reset err_cnt",  32'(err_cnt_a),   32'd0);
        chk("reset expected", 32'(expected_a),  32'h00);

        // Lock, corrupt word, gap, clears, loss of lock and relock
        for (int i = 0; i < NV; i++) begin
            drv(tbl[i].v, tbl[i].d, tbl[i].clr);
            chk($sformatf("vec%0d locked", i),   32'(locked_a),    32'(tbl[i].lk));
            chk($sformatf("vec%0d pulse", i),    32'(err_pulse_a), 32'(tbl[i].pl));
            chk($sformatf("vec%0d err_cnt", i),  32'(err_cnt_a),   32'(tbl[i].ec));
            chk($sformatf("vec%0d expected", i), 32'(expected_a),  32'(tbl[i].pr));
            chk($sformatf("vec%0d B.err_cnt", i), 32'(err_cnt_b),  32'(mb.ec));
            chk($sformatf("vec%0d B.locked", i),  32'(locked_b),   32'(mb.st == 2));
        end

        // Zeros in HUNT are ignored
        do_reset();
        drv(1'b1, 8'h00, 1'b0);
        drv(1'b1, 8'h00, 1'b0);
        chk("hunt zeros locked",   32'(locked_a),   32'd0);
        chk("hunt zeros expected", 32'(expected_a), 32'h00);
        send_seq(8'h01, 8'h80, 8'h40, 8'h20, 8'h10);
        chk("hunt lock locked",   32'(locked_a),   32'd1);
        chk("hunt lock expected", 32'(expected_a), 32'h88);

        // Zero in SYNC drops back to HUNT; next nonzero word reseeds
        do_reset();
        drv(1'b1, 8'h01, 1'b0);
        drv(1'b1, 8'h80, 1'b0);
        drv(1'b1, 8'h00, 1'b0);
        chk("sync zero expected", 32'(expected_a), 32'h40);
        drv(1'b1, 8'h80, 1'b0);
        chk("sync zero reseed", 32'(expected_a), 32'h40);
        drv(1'b1, 8'h40, 1'b0);
        drv(1'b1, 8'h20, 1'b0);
        drv(1'b1, 8'h10, 1'b0);
        chk("sync zero not yet locked", 32'(locked_a), 32'd0);
        drv(1'b1, 8'h88, 1'b0);
        chk("sync zero relocked", 32'(locked_a),   32'd1);
        chk("sync zero relock exp", 32'(expected_a), 32'hC4);

        // Narrow counter saturates; async reset drops lock mid-stream
        do_reset();
        send_seq(8'h01, 8'h80, 8'h40, 8'h20, 8'h10);
        send_seq(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("sat B.err_cnt", 32'(err_cnt_b), 32'd3);
        chk("sat B.locked",  32'(locked_b),  32'd1);
        chk("sat A.err_cnt", 32'(err_cnt_a), 32'd3);
        chk("sat A.locked",  32'(locked_a),  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst B.locked",  32'(locked_b),  32'd0);
        chk("async rst B.err_cnt", 32'(err_cnt_b), 32'd0);
        chk("async rst A.err_cnt", 32'(err_cnt_a), 32'd0);
        do_reset();

        // Randomized traffic against the model
        send_seq(8'h01, 8'h80, 8'h40, 8'h20, 8'h10);
        cmp_models("rnd lock");
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      d = 8'h00;
            else if (r < 3)  d = 8'($urandom);
            else             d = ma.pred;
            drv(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 15) == 0));
            cmp_models($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
